// File: rtl/mult_iter.sv
// ============================================================================
// mult_iter : sequential 32x32 signed multiplier, radix-2 Booth, 1 bit/clock.
// Macro MULT_EXCEPTION_EN enables the signed-32 overflow flag (else tied 0).
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mult_iter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd31;

    state_t      state;
    state_t      state_next;
    logic        load;
    logic        step;
    logic        finish;

    logic [31:0] mcand;
    logic [32:0] hi;
    logic [31:0] lo;
    logic        q_m1;
    logic [4:0]  count;

    logic [32:0] a_ext;
    logic [32:0] hi_sum;
    logic [32:0] hi_next;
    logic [31:0] lo_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (ctrl_MULT) begin
                    state_next = S_RUN;
                    load       = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                // A new start request aborts and restarts the operation.
                if (ctrl_MULT) begin
                    load = 1'b1;
                end else begin
                    step = 1'b1;
                    if (count == LAST_ITER) begin
                        finish     = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy           = (state == S_RUN);
    assign data_resultRDY = (state == S_DONE);

    // ------------------------------------------------------------------
    // Booth step: add/sub into the 33-bit hi, then arithmetic shift of
    // {hi, lo, q_m1}. The guard bit keeps A = 0x80000000 exact.
    // ------------------------------------------------------------------
    assign a_ext = {mcand[31], mcand};

    always_comb begin
        hi_sum = hi;
        case ({lo[0], q_m1})
            2'b01:   hi_sum = hi + a_ext;
            2'b10:   hi_sum = hi - a_ext;
            default: hi_sum = hi;
        endcase
    end

    assign hi_next = {hi_sum[32], hi_sum[32:1]};
    assign lo_next = {hi_sum[0], lo[31:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= 32'd0;
            hi    <= 33'd0;
            lo    <= 32'd0;
            q_m1  <= 1'b0;
            count <= 5'd0;
        end else if (load) begin
            mcand <= data_operandA;
            hi    <= 33'd0;
            lo    <= data_operandB;
            q_m1  <= 1'b0;
            count <= 5'd0;
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            q_m1  <= lo[0];
            count <= count + 5'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result <= 32'd0;
        end else if (finish) begin
            data_result <= lo_next;
        end
    end

`ifdef MULT_EXCEPTION_EN
    // Overflow when the upper word is not a pure sign extension of the lower.
    logic exc_next;
    assign exc_next = (hi_next[31:0] != {32{lo_next[31]}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_exception <= 1'b0;
        end else if (finish) begin
            data_exception <= exc_next;
        end
    end
`else
    assign data_exception = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_iter.sv
// Directed testbench for mult_iter: latency, products, overflow, abort, reset.
`default_nettype none

module tb_mult_iter;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mult_iter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic exc(input logic e);
`ifdef MULT_EXCEPTION_EN
        return e;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        tick();
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits for RDY after a start at e0; optionally restarts on the RDY cycle.
    task automatic wait_check(input string tag, input logic [31:0] er, input logic ee,
                              input logic restart, input logic [31:0] na, input logic [31:0] nb);
        int   n;
        logic busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (!data_resultRDY && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check32({tag, " latency"}, n, 32);
        check1({tag, " busy e0..e31"}, busy_ok, 1'b1);
        check1({tag, " busy at rdy"}, busy, 1'b0);
        check32({tag, " result"}, data_result, er);
        check1({tag, " exception"}, data_exception, ee);
        if (restart) begin
            start_op(na, nb);
            check1({tag, " rdy after restart"}, data_resultRDY, 1'b0);
            check1({tag, " busy after restart"}, busy, 1'b1);
        end else begin
            tick();
            check1({tag, " rdy drop"}, data_resultRDY, 1'b0);
            check32({tag, " result hold"}, data_result, er);
        end
    endtask

    initial begin
        logic rdy_seen;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #2;
        check32("reset result", data_result, 32'd0);
        check1("reset exception", data_exception, 1'b0);
        check1("reset rdy", data_resultRDY, 1'b0);
        check1("reset busy", busy, 1'b0);
        #21 reset_n = 1'b1;
        tick();

        // 3 * -7
        start_op(32'd3, 32'hFFFF_FFF9);
        check1("3x-7 busy e0", busy, 1'b1);
        wait_check("3x-7", 32'hFFFF_FFEB, 1'b0, 1'b0, 32'd0, 32'd0);

        // 0x7FFFFFFF * 2
        start_op(32'h7FFF_FFFF, 32'd2);
        wait_check("max x 2", 32'hFFFF_FFFE, exc(1'b1), 1'b0, 32'd0, 32'd0);

        // 0x80000000 * -1, then -1 * -1 started on the RDY cycle
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_check("min x -1", 32'h8000_0000, exc(1'b1), 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_check("-1 x -1", 32'h0000_0001, 1'b0, 1'b0, 32'd0, 32'd0);

        // 2^16 * 2^16, then 2^15 * -2^16
        start_op(32'h0001_0000, 32'h0001_0000);
        wait_check("2^16 sq", 32'h0000_0000, exc(1'b1), 1'b0, 32'd0, 32'd0);
        start_op(32'h0000_8000, 32'hFFFF_0000);
        wait_check("2^15 x -2^16", 32'h8000_0000, 1'b0, 1'b0, 32'd0, 32'd0);

        // B = 0x80000000 with small A
        start_op(32'd3, 32'h8000_0000);
        wait_check("3 x min", 32'h8000_0000, exc(1'b1), 1'b0, 32'd0, 32'd0);

        // Abort: 5*6 restarted with 2*9 at cycle 10
        start_op(32'd5, 32'd6);
        rdy_seen = 1'b0;
        repeat (9) begin
            if (data_resultRDY) rdy_seen = 1'b1;
            tick();
        end
        start_op(32'd2, 32'd9);
        check1("abort no rdy", rdy_seen, 1'b0);
        wait_check("abort 2x9", 32'd18, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset mid-run at cycle 15
        start_op(32'd5, 32'd6);
        repeat (14) tick();
        #3 reset_n = 1'b0;
        #1;
        check32("midreset result", data_result, 32'd0);
        check1("midreset exception", data_exception, 1'b0);
        check1("midreset rdy", data_resultRDY, 1'b0);
        check1("midreset busy", busy, 1'b0);
        repeat (3) tick();
        reset_n  = 1'b1;
        rdy_seen = 1'b0;
        repeat (40) begin
            if (data_resultRDY || busy) rdy_seen = 1'b1;
            tick();
        end
        check1("post reset idle", rdy_seen, 1'b0);
        start_op(32'd4, 32'd4);
        wait_check("4x4", 32'd16, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
